// File: rtl/lif_scheduler_if.sv
// Control and event bundle for lif_scheduler: current writes, step
// parameters, step status and the spike event handshake.
interface lif_scheduler_if #(
    parameter int N_NEURONS = 4,
    parameter int IDXW      = $clog2(N_NEURONS)
) ();
    logic                 cur_we;
    logic [IDXW-1:0]      cur_idx;
    logic [7:0]           cur_data;
    logic [7:0]           threshold;
    logic [2:0]           leak_shift;
    logic                 step_start;
    logic                 busy;
    logic                 step_done;
    logic [N_NEURONS-1:0] spike_vec;
    logic                 evt_valid;
    logic [IDXW-1:0]      evt_idx;
    logic                 evt_ready;

    modport master (
        output cur_we, cur_idx, cur_data, threshold, leak_shift, step_start, evt_ready,
        input  busy, step_done, spike_vec, evt_valid, evt_idx
    );

    modport slave (
        input  cur_we, cur_idx, cur_data, threshold, leak_shift, step_start, evt_ready,
        output busy, step_done, spike_vec, evt_valid, evt_idx
    );
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler. One shared update
// datapath walks all virtual neurons per step; spikes leave as indexed
// valid/ready events and the spike vector is published at step end.
module lif_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int IDXW      = $clog2(N_NEURONS)
) (
    input  logic           clk,
    input  logic           reset,
    lif_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} fsm_t;

    fsm_t                       fsm;
    logic [N_NEURONS-1:0][7:0]  state;
    logic [N_NEURONS-1:0][7:0]  cur;
    logic [N_NEURONS-1:0]       pend;
    logic [N_NEURONS-1:0]       spike_vec_q;
    logic [7:0]                 thr_q;
    logic [2:0]                 shift_q;
    logic [IDXW-1:0]            idx;
    logic                       busy_q;
    logic                       step_done_q;
    logic                       evt_valid_q;
    logic [IDXW-1:0]            evt_idx_q;

    logic [7:0]                 retained;
    logic [8:0]                 sum9;
    logic [7:0]                 sum_sat;
    logic                       spk;
    logic                       last;

    assign bus.busy      = busy_q;
    assign bus.step_done = step_done_q;
    assign bus.spike_vec = spike_vec_q;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_idx   = evt_idx_q;

    // Shared datapath: decay, integrate with saturation, threshold compare.
    always_comb begin
        retained = state[idx] >> shift_q;
        sum9     = {1'b0, cur[idx]} + {1'b0, retained};
        sum_sat  = sum9[8] ? 8'hFF : sum9[7:0];
        spk      = (sum_sat >= thr_q);
        last     = (idx == IDXW'(N_NEURONS - 1));
    end

    // Current registers; writable any time. A write to the neuron being
    // updated lands at the same edge, so the update sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur <= '0;
        else if (bus.cur_we)
            cur[bus.cur_idx] <= bus.cur_data;
    end

    // Step sequencer with registered status/event outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm         <= IDLE;
            state       <= '0;
            pend        <= '0;
            spike_vec_q <= '0;
            thr_q       <= '0;
            shift_q     <= '0;
            idx         <= '0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
        end else begin
            step_done_q <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (bus.step_start) begin
                        thr_q   <= bus.threshold;
                        shift_q <= bus.leak_shift;
                        idx     <= '0;
                        pend    <= '0;
                        busy_q  <= 1'b1;
                        fsm     <= UPDATE;
                    end
                end
                UPDATE: begin
                    state[idx] <= spk ? 8'd0 : sum_sat;
                    if (spk) begin
                        pend[idx]   <= 1'b1;
                        evt_valid_q <= 1'b1;
                        evt_idx_q   <= idx;
                        fsm         <= EMIT;
                    end else if (last) begin
                        step_done_q <= 1'b1;
                        fsm         <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                EMIT: begin
                    // Event is held unchanged until the consumer takes it.
                    if (bus.evt_ready) begin
                        evt_valid_q <= 1'b0;
                        if (last) begin
                            step_done_q <= 1'b1;
                            fsm         <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                            fsm <= UPDATE;
                        end
                    end
                end
                DONE: begin
                    spike_vec_q <= pend;
                    busy_q      <= 1'b0;
                    fsm         <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lif_scheduler.md
# lif_scheduler

Time-multiplexed sequencer that shares one leaky integrate-and-fire update datapath among N_NEURONS virtual neurons. Each neuron's membrane state and input current live in per-neuron registers. A `step_start` pulse makes the scheduler walk every neuron once: decay, integrate, threshold and reset. Spikes are emitted as indexed events over a valid/ready handshake, and a spike vector is published when the step completes.

## Interface
Parameters:
- N_NEURONS, 4: number of virtual neurons; must be ≥2.
- IDXW, $clog2(N_NEURONS): neuron index width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cur_we  in  1  write strobe for a current register.
- cur_idx  in  IDXW  neuron addressed by cur_we.
- cur_data  in  8  unsigned input current value.
- threshold  in  8  spike threshold, sampled at step start.
- leak_shift  in  3  decay shift (retained = state >> leak_shift), sampled at step start.
- step_start  in  1  begins a step when sampled in IDLE.
- busy  out  1  high while a step is in progress (UPDATE/EMIT/DONE).
- step_done  out  1  one-cycle pulse in the DONE state.
- spike_vec  out  N_NEURONS  bit i = neuron i spiked in the last completed step.
- evt_valid  out  1  spike event available.
- evt_idx  out  IDXW  index of the spiking neuron.
- evt_ready  in  1  consumer accepts the event.

## Operation
- Storage:
  - state[i]: 8-bit membrane state.
  - cur[i]: 8-bit current; persists across steps until rewritten.
  - pend: N_NEURONS-bit shadow spike vector.
  - thr_q, shift_q: latched step parameters.
  - idx: neuron pointer.
- Reset (asynchronous, high): all state[i], cur[i], pend, spike_vec, idx, thr_q and shift_q clear to 0. FSM goes to IDLE. busy, step_done and evt_valid are 0; evt_idx is 0.
- FSM states: IDLE, UPDATE, EMIT, DONE.
  - IDLE: on step_start, latch threshold→thr_q and leak_shift→shift_q, set idx=0, clear pend, go to UPDATE. step_start is ignored in every other state.
  - UPDATE (one cycle per neuron):
    - retained = state[idx] >> shift_q. Shift 0 means no leak; shift 7 leaves at most 1.
    - sum = cur[idx] + retained, computed at 9 bits and saturated to 255.
    - spk = (sum ≥ thr_q).
    - Write state[idx] ← spk ? 0 : sum.
    - If spk: set pend[idx] and go to EMIT.
    - Else if idx == N_NEURONS-1: go to DONE.
    - Else: idx++ and stay in UPDATE.
  - EMIT: evt_valid=1 and evt_idx=idx, both held stable until evt_ready. On evt_valid&&evt_ready, go to DONE if idx is last; otherwise idx++ and go to UPDATE.
  - DONE: step_done=1, spike_vec ← pend, go to IDLE.
- cur_we is accepted in any state; the write lands at the clock edge.
  - If a write targets idx in the same cycle that neuron is in UPDATE, the update uses the pre-write value.
  - The new value applies from the next step.
- thr_q = 0 makes every neuron spike each step.
- Changes to threshold or leak_shift mid-step have no effect on the step in progress.
- spike_vec changes only in DONE or on reset.

## Timing
- Time is measured from the edge that samples step_start in IDLE (edge k).
- busy rises after edge k.
- UPDATE for neuron i occupies one cycle. If that neuron spikes, add its EMIT cycles: at least 1, plus one cycle per cycle evt_ready is low.
- With no spikes, step_done is high in cycle k+N_NEURONS+1, and busy falls after the following edge.
- With s spikes and evt_ready tied high, step_done comes s cycles later than the no-spike case.
- The earliest next step_start is accepted in the cycle after DONE.
- evt_valid must not drop or change evt_idx while evt_ready is low.
- Asynchronous reset mid-step aborts immediately:
  - no step_done;
  - spike_vec = 0;
  - states partially updated before reset are discarded (all zero).

## Test plan
- Leak and integrate, N_NEURONS=4, threshold=200, leak_shift=1, cur[0]=120, others 0. Over three steps neuron 0's state goes 120 → 180 → spike. In step 3: evt_idx=0, spike_vec=4'b0001, state[0]=0. No events from neurons 1–3.
- Saturation, threshold=255, leak_shift=0, cur[2]=200:
  - step 1: no spike, state[2]=200;
  - step 2: sum 400 saturates to 255, spike, evt_idx=2, state[2]=0.
- Backpressure: all cur=50, threshold=40, evt_ready low for 5 cycles on the first event.
  - evt_valid is held with evt_idx=0 and no further UPDATE happens.
  - Four events arrive in order 0,1,2,3.
  - step_done is 5 cycles later than with evt_ready tied high; spike_vec=4'b1111.
- No-spike latency: threshold=255, all cur=1. step_done is exactly N_NEURONS+1 cycles after the step_start edge, busy spans that interval, and evt_valid stays 0. A step_start issued while busy is ignored.
- Write collision: cur[1] is written to 100 in the cycle neuron 1 is in UPDATE (old value 10, threshold=50).
  - That step: neuron 1 does not spike, state[1]=10.
  - Next step, leak_shift=1: 5+100=105, spike.
- Reset mid-EMIT: assert reset while evt_valid=1. Outputs are zero immediately, the FSM is in IDLE and state/cur are cleared; the next step with all cur=0 produces no spikes.
